// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the radix-2 Booth controller
package booth_pkg;

  localparam int BOOTH_N     = 5;
  localparam int BOOTH_CNT_W = 3;

  // {X1,X0} decision pairs that require an ALU operation
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/booth_iter_counter.sv
// rtl/booth_iter_counter.sv - Booth iteration counter with terminal-count flag
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int N     = BOOTH_N,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // clear wins over enable; the controller never increments past N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - Moore sequencer for the radix-2 Booth multiplier datapath
module booth_controller
  import booth_pkg::*;
#(
  parameter int N     = BOOTH_N,
  parameter int CNT_W = BOOTH_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic X1,
  input  logic X0,
  output logic ld_X,
  output logic ld_Y,
  output logic ld_A,
  output logic ld_ff,
  output logic init_A,
  output logic init_ff,
  output logic add,
  output logic sub,
  output logic shift_x,
  output logic shift_a,
  output logic busy,
  output logic done
);

  state_e state_q;
  state_e state_d;
  logic   last_iter;

  booth_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == ST_LOAD),
    .en_i  ((state_q == ST_SHIFT) && !last_iter),
    .tc_o  (last_iter)
  );

  // next-state: start only matters in IDLE, unused encodings fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_EVAL;
      ST_EVAL:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = last_iter ? ST_DONE : ST_EVAL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state register; reset forces IDLE so every strobe drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // strobe decode from state (and the Booth pair while in EVAL only)
  always_comb begin
    ld_X    = 1'b0;
    ld_Y    = 1'b0;
    ld_A    = 1'b0;
    ld_ff   = 1'b0;
    init_A  = 1'b0;
    init_ff = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift_x = 1'b0;
    shift_a = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_X    = 1'b1;
        ld_Y    = 1'b1;
        init_A  = 1'b1;
        init_ff = 1'b1;
        busy    = 1'b1;
      end
      ST_EVAL: begin
        busy = 1'b1;
        if ({X1, X0} == BOOTH_ADD) begin
          add  = 1'b1;
          ld_A = 1'b1;
        end else if ({X1, X0} == BOOTH_SUB) begin
          sub  = 1'b1;
          ld_A = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_a = 1'b1;
        shift_x = 1'b1;
        ld_ff   = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - directed self-checking bench with a behavioural Booth datapath
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic X1, X0;
  logic ld_X, ld_Y, ld_A, ld_ff, init_A, init_ff;
  logic add, sub, shift_x, shift_a, busy, done;

  int checks = 0;
  int errors = 0;

  logic [4:0] xin = 5'd0;
  logic [4:0] yin = 5'd0;
  logic [5:0] a_m = 6'd0;
  logic [4:0] x_m = 5'd0;
  logic [4:0] y_m = 5'd0;
  logic       ff_m = 1'b0;

  logic [11:0] outs;
  logic [9:0]  result;

  always #5 clk = ~clk;

  booth_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .X1      (X1),
    .X0      (X0),
    .ld_X    (ld_X),
    .ld_Y    (ld_Y),
    .ld_A    (ld_A),
    .ld_ff   (ld_ff),
    .init_A  (init_A),
    .init_ff (init_ff),
    .add     (add),
    .sub     (sub),
    .shift_x (shift_x),
    .shift_a (shift_a),
    .busy    (busy),
    .done    (done)
  );

  assign outs   = {ld_X, ld_Y, ld_A, ld_ff, init_A, init_ff, add, sub, shift_x, shift_a, busy, done};
  assign X1     = x_m[0];
  assign X0     = ff_m;
  assign result = {a_m[4:0], x_m};

  // datapath with one guard bit on A so the most negative operands do not overflow
  always @(posedge clk) begin
    if (ld_X)    x_m <= xin;
    if (ld_Y)    y_m <= yin;
    if (init_A)  a_m <= 6'd0;
    if (init_ff) ff_m <= 1'b0;
    if (ld_A)    a_m <= add ? a_m + {y_m[4], y_m} : a_m - {y_m[4], y_m};
    if (shift_a) {a_m, x_m} <= {a_m[5], a_m, x_m[4:1]};
    if (ld_ff)   ff_m <= x_m[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE
  task automatic run_op(input string tag, input logic [4:0] xv, input logic [4:0] yv,
                        input logic [9:0] prod, input logic [4:0] add_m, input logic [4:0] sub_m,
                        input logic [12:0] smask, input bit hold);
    int dones;
    int it;
    logic [11:0] exp;
    xin   = xv;
    yin   = yv;
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1)       exp = 12'hCC2;
      else if (c == 12) exp = 12'h003;
      else if (c == 13) exp = 12'h000;
      else if (c % 2 == 0) begin
        it  = (c - 2) / 2;
        exp = 12'h002 | (add_m[it] ? 12'h220 : 12'h0) | (sub_m[it] ? 12'h210 : 12'h0);
      end else          exp = 12'h10E;
      check($sformatf("%s_cyc%0d", tag, c), {20'd0, outs}, {20'd0, exp});
      dones += int'(done);
      if (c < 13) start = hold | smask[c];
    end
    check($sformatf("%s_done_count", tag), dones, 1);
    check($sformatf("%s_product", tag), {22'd0, result}, {22'd0, prod});
  endtask

  initial begin
    #2;
    check("reset_outs", {20'd0, outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {20'd0, outs}, 32'd0);

    run_op("x3_y5",    5'd3,  5'd5,  10'd15,  5'b00100, 5'b00001, 13'd0, 1'b0);
    run_op("xm3_y7",   5'h1D, 5'd7,  10'h3EB, 5'b00010, 5'b00101, 13'd0, 1'b0);
    run_op("xm16_ym16",5'h10, 5'h10, 10'd256, 5'b00000, 5'b10000, 13'd0, 1'b0);
    run_op("x0_y11",   5'd0,  5'd11, 10'd0,   5'b00000, 5'b00000, 13'd0, 1'b0);
    run_op("start_ign",5'd3,  5'd5,  10'd15,  5'b00100, 5'b00001, 13'b0_1000_1000_1000, 1'b0);

    // abort in the third EVAL
    start = 1'b1;
    xin   = 5'd3;
    yin   = 5'd5;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 6; c++) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs_async", {20'd0, outs}, 32'd0);
    @(negedge clk);
    check("abort_outs_held", {20'd0, outs}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_after", {20'd0, outs}, 32'd0);
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    run_op("after_abort", 5'd7, 5'd3, 10'd21, 5'b01000, 5'b00001, 13'd0, 1'b0);

    // start held high across three consecutive products
    run_op("b2b_0", 5'd2,  5'd6, 10'd12,  5'b00100, 5'b00010, 13'd0, 1'b1);
    run_op("b2b_1", 5'h1F, 5'd9, 10'h3F7, 5'b00000, 5'b00001, 13'd0, 1'b1);
    run_op("b2b_2", 5'd3,  5'd5, 10'd15,  5'b00100, 5'b00001, 13'd0, 1'b0);
    @(negedge clk);
    check("final_idle", {20'd0, outs}, 32'd0);
    check("final_hold_result", {22'd0, result}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
